mem_access_unit: RTL and testbench

//  MEM-stage controller between the EX/MEM pipeline register and the word-only data memory.

---
 rtl/mem_access_pkg.sv | 33 +++
 rtl/mem_access_unit_if.sv | 37 +++
 rtl/mem_access_unit_byte_lane.sv | 65 ++++++
 rtl/mem_access_unit.sv | 119 +++++++++++
 tb/tb_mem_access_unit.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage access controller: op field layout,
// size codes, FSM states and the alignment predicate.
package mem_access_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Mirrors req_op: [3]=store, [2]=unsigned, [1:0]=size
    typedef struct packed {
        logic       store;
        logic       uns;
        logic [1:0] size;
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SZ_HALF && a[0]) ||
               (size == SZ_WORD && a != 2'b00) ||
               (size == SZ_ILL);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bundle and the word-memory bus bundle.
interface mem_req_if;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  stall, load_data, load_valid, misaligned
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output stall, load_data, load_valid, misaligned
    );
endinterface

interface mem_dm_if;
    logic [31:0] dm_address;
    logic        dm_mem_read;
    logic        dm_mem_write;
    logic [31:0] dm_data_in;
    logic [31:0] dm_data_out;

    modport master (
        output dm_address, dm_mem_read, dm_mem_write, dm_data_in,
        input  dm_data_out
    );
    modport slave (
        input  dm_address, dm_mem_read, dm_mem_write, dm_data_in,
        output dm_data_out
    );
endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// Combinational big-endian lane logic: load extract/extend and sub-word store merge.
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [NUM_LANES-1:0][LANE_W-1:0] rb, wb, mb;
    logic [1:0][15:0]                 rh;
    logic [7:0]                       sel_b;
    logic [15:0]                      sel_h;

    assign rb = rdata;
    assign rh = rdata;
    assign wb = wdata;

    // Byte address 0 is the MSB lane, so the packed index is the inverted offset
    assign sel_b = rb[~lane];
    assign sel_h = rh[~lane[1]];

    always_comb begin
        load_val = rdata;
        case (size)
            SZ_BYTE: load_val = {{24{~uns & sel_b[7]}}, sel_b};
            SZ_HALF: load_val = {{16{~uns & sel_h[15]}}, sel_h};
            default: load_val = rdata;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int P = NUM_LANES - 1 - i;
        logic       be;
        logic [7:0] src;

        always_comb begin
            be  = 1'b1;
            src = wb[P];
            case (size)
                SZ_BYTE: begin
                    be  = (lane == 2'(i));
                    src = wb[0];
                end
                SZ_HALF: begin
                    be  = (lane[1] == 1'(i / 2));
                    src = (i % 2 == 0) ? wb[1] : wb[0];
                end
                default: begin
                    be  = 1'b1;
                    src = wb[P];
                end
            endcase
        end

        assign mb[P] = be ? src : rb[P];
    end

    assign merged = mb;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: byte-addressed loads/stores onto a word-only memory,
// with read-modify-write for sub-word stores and a pipeline stall until done.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int READ_LAT = 1
)(
    input  logic     clk,
    input  logic     reset,
    mem_req_if.slave req,
    mem_dm_if.master dm
);

    localparam int CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

    state_t            state, state_n;
    op_t               op_in, op_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       load_q;
    logic              mis_q;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       lane_load, lane_merged;
    logic              unused_addr;

    assign op_in       = op_t'(req.req_op);
    assign unused_addr = ^req.req_addr[31:ADDR_W+2];

    byte_lane_unit u_lane (
        .size     (op_q.size),
        .uns      (op_q.uns),
        .lane     (addr_q[1:0]),
        .rdata    (dm.dm_data_out),
        .wdata    (wdata_q),
        .load_val (lane_load),
        .merged   (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            mis_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (req.req_valid) begin
                        op_q    <= op_in;
                        addr_q  <= req.req_addr[ADDR_W+1:0];
                        wdata_q <= req.req_wdata;
                        mis_q   <= is_misaligned(op_in.size, req.req_addr[1:0]);
                        cnt     <= CNT_W'(READ_LAT);
                    end
                end
                ST_RD: begin
                    // Last read cycle: dm_data_out is valid; a sub-word store reuses
                    // wdata_q to carry the merged word into WR.
                    if (cnt != '0)
                        cnt <= cnt - CNT_W'(1);
                    else if (op_q.store)
                        wdata_q <= lane_merged;
                    else
                        load_q <= lane_load;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n         = state;
        req.stall       = 1'b0;
        req.load_valid  = 1'b0;
        req.misaligned  = 1'b0;
        dm.dm_mem_read  = 1'b0;
        dm.dm_mem_write = 1'b0;
        case (state)
            ST_IDLE: begin
                req.stall = req.req_valid;
                if (req.req_valid) begin
                    if (is_misaligned(op_in.size, req.req_addr[1:0]))
                        state_n = ST_DONE;
                    else if (op_in.store && op_in.size == SZ_WORD)
                        state_n = ST_WR;
                    else
                        state_n = ST_RD;
                end
            end
            ST_RD: begin
                req.stall      = 1'b1;
                dm.dm_mem_read = 1'b1;
                if (cnt == '0)
                    state_n = op_q.store ? ST_WR : ST_DONE;
            end
            ST_WR: begin
                req.stall       = 1'b1;
                dm.dm_mem_write = 1'b1;
                state_n         = ST_DONE;
            end
            ST_DONE: begin
                req.load_valid = ~mis_q & ~op_q.store;
                req.misaligned = mis_q;
                state_n        = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign req.load_data = load_q;
    assign dm.dm_address = 32'(addr_q[ADDR_W+1:2]);
    assign dm.dm_data_in = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: shadow-memory model predicts every cycle of each access.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_req_if rq ();
    mem_dm_if  dmi ();

    mem_access_unit #(.ADDR_W(7), .READ_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (rq),
        .dm    (dmi)
    );

    // Word memory with one cycle of read latency
    logic [31:0] mem     [128];
    logic [31:0] ref_mem [128];
    logic [31:0] dout;
    assign dmi.dm_data_out = dout;

    always @(posedge clk) begin
        if (dmi.dm_mem_write) mem[dmi.dm_address[6:0]] <= dmi.dm_data_in;
        if (dmi.dm_mem_read)  dout <= mem[dmi.dm_address[6:0]];
    end

    typedef struct {
        bit          stall, rd, wr, lv, mis, ck_ld, ck_addr, ck_din;
        logic [31:0] ld, addr, din;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    bit          chk_en = 1'b0;
    logic [31:0] last_ld, last_din;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (q.size() > 0) e = q.pop_front();
            else              e = '{default: 0};
            chk("stall",        32'(rq.stall),           32'(e.stall));
            chk("dm_mem_read",  32'(dmi.dm_mem_read),    32'(e.rd));
            chk("dm_mem_write", 32'(dmi.dm_mem_write),   32'(e.wr));
            chk("load_valid",   32'(rq.load_valid),      32'(e.lv));
            chk("misaligned",   32'(rq.misaligned),      32'(e.mis));
            if (e.ck_ld)   chk("load_data",  rq.load_data,     e.ld);
            if (e.ck_addr) chk("dm_address", dmi.dm_address,   e.addr);
            if (e.ck_din)  chk("dm_data_in", dmi.dm_data_in,   e.din);
            if (e.lv) last_ld  = rq.load_data;
            if (e.wr) last_din = dmi.dm_data_in;
        end
    end

    // Reference rules, written as shifts and masks on a big-endian word
    function automatic bit m_mis(input logic [3:0] op, input logic [31:0] a);
        case (op[1:0])
            2'b01:   return a[0];
            2'b10:   return a[1:0] != 2'b00;
            2'b11:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [3:0] op, input logic [31:0] a);
        int          sh;
        logic [31:0] v;
        case (op[1:0])
            2'b00: begin
                sh = 8 * (3 - int'(a[1:0]));
                v  = (w >> sh) & 32'hFF;
                if (!op[2] && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                sh = a[1] ? 0 : 16;
                v  = (w >> sh) & 32'hFFFF;
                if (!op[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [3:0] op,
                                            input logic [31:0] a, input logic [31:0] wd);
        int          sh;
        logic [31:0] mask;
        case (op[1:0])
            2'b00: begin
                sh   = 8 * (3 - int'(a[1:0]));
                mask = 32'hFF << sh;
                return (w & ~mask) | ((wd & 32'hFF) << sh);
            end
            2'b01: begin
                sh   = a[1] ? 0 : 16;
                mask = 32'hFFFF << sh;
                return (w & ~mask) | ((wd & 32'hFFFF) << sh);
            end
            default: return wd;
        endcase
    endfunction

    function automatic exp_t rec(input bit stall, input bit rd, input bit wr);
        exp_t e;
        e       = '{default: 0};
        e.stall = stall;
        e.rd    = rd;
        e.wr    = wr;
        return e;
    endfunction

    // Present one request (entered and left at posedge+1), held until its DONE cycle ends
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
        logic [6:0]  idx;
        exp_t        e;
        logic [31:0] nw;
        int          n;
        idx = a[8:2];
        rq.req_valid = 1'b1;
        rq.req_op    = op;
        rq.req_addr  = a;
        rq.req_wdata = wd;
        q.push_back(rec(1, 0, 0));
        if (m_mis(op, a)) begin
            e = rec(0, 0, 0); e.mis = 1; q.push_back(e);
            n = 2;
        end else if (!op[3]) begin
            e = rec(1, 1, 0); e.ck_addr = 1; e.addr = 32'(idx);
            q.push_back(e); q.push_back(e);
            e = rec(0, 0, 0); e.lv = 1; e.ck_ld = 1; e.ld = m_load(ref_mem[idx], op, a);
            q.push_back(e);
            n = 4;
        end else if (op[1:0] == 2'b10) begin
            e = rec(1, 0, 1); e.ck_addr = 1; e.addr = 32'(idx); e.ck_din = 1; e.din = wd;
            q.push_back(e);
            ref_mem[idx] = wd;
            q.push_back(rec(0, 0, 0));
            n = 3;
        end else begin
            e = rec(1, 1, 0); e.ck_addr = 1; e.addr = 32'(idx);
            q.push_back(e); q.push_back(e);
            nw = m_store(ref_mem[idx], op, a, wd);
            e = rec(1, 0, 1); e.ck_addr = 1; e.addr = 32'(idx); e.ck_din = 1; e.din = nw;
            q.push_back(e);
            ref_mem[idx] = nw;
            q.push_back(rec(0, 0, 0));
            n = 5;
        end
        repeat (n) @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rq.req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[16]     = 32'h8899_AABB;
        ref_mem[16] = 32'h8899_AABB;

        reset        = 1'b1;
        rq.req_valid = 1'b0;
        rq.req_op    = 4'h0;
        rq.req_addr  = 32'h0;
        rq.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        e = rec(0, 0, 0); e.ck_ld = 1; e.ck_addr = 1; e.ck_din = 1;
        q.push_back(e);
        idle(2);

        issue(4'b0000, 32'h41, $urandom); chk("pin_lb_41",  last_ld, 32'hFFFF_FF99);
        issue(4'b0100, 32'h43, $urandom); chk("pin_lbu_43", last_ld, 32'h0000_00BB);
        issue(4'b0001, 32'h42, $urandom); chk("pin_lh_42",  last_ld, 32'hFFFF_AABB);
        issue(4'b0101, 32'h40, $urandom); chk("pin_lhu_40", last_ld, 32'h0000_8899);
        issue(4'b0001, 32'h41, $urandom);
        idle(1);

        issue(4'b1010, 32'h08, 32'h1234_5678);
        issue(4'b0010, 32'h08, $urandom);     chk("pin_lw_08", last_ld,  32'h1234_5678);
        issue(4'b1000, 32'h0A, 32'h0000_00EE); chk("pin_sb_0a", last_din, 32'h1234_EE78);
        issue(4'b1001, 32'h08, 32'h0000_CAFE); chk("pin_sh_08", last_din, 32'hCAFE_EE78);
        issue(4'b0010, 32'h08, $urandom);     chk("pin_lw_rmw", last_ld, 32'hCAFE_EE78);

        issue(4'b0010, 32'h40, $urandom);
        issue(4'b1010, 32'h44, 32'hDEAD_BEEF);
        issue(4'b0000, 32'h45, $urandom);     chk("pin_lb_45", last_ld, 32'hFFFF_FFAD);
        issue(4'b0011, 32'h40, $urandom);
        issue(4'b1011, 32'h44, $urandom);
        idle(1);

        // Reset lands on the first RD cycle of an SB
        rq.req_valid = 1'b1;
        rq.req_op    = 4'b1000;
        rq.req_addr  = 32'h0A;
        rq.req_wdata = 32'h0000_0011;
        q.push_back(rec(1, 0, 0));
        e = rec(1, 1, 0); e.ck_addr = 1; e.addr = 32'd2; q.push_back(e);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset        = 1'b0;
        rq.req_valid = 1'b0;
        e = rec(0, 0, 0); e.ck_ld = 1; e.ck_addr = 1; e.ck_din = 1;
        q.push_back(e);
        idle(4);

        issue(4'b1010, 32'h200, 32'h5A5A_5A5A);
        issue(4'b0010, 32'h000, $urandom);    chk("pin_wrap", last_ld, 32'h5A5A_5A5A);

        for (int i = 0; i < 200; i++) begin
            issue(4'($urandom_range(0, 15)), 32'($urandom_range(0, 1023)), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);
        chk_en = 1'b0;

        for (int i = 0; i < 128; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
